alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single 8-bit ALU between two requesters, for example the instruction sequencer and the address-calculation unit. It arbitrates round-robin, drives the ALU's A, B and FunSel inputs, and waits for the ALU's clocked Flags register to update. It then returns the result, the flags and the requester ID over a valid/ready response channel. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

Parameters:
DATA_W, 8, operand and result width (matches ALU A/B/OutALU).
FUNSEL_W, 4, function-select width (matches ALU FunSel).
FLAG_W, 4, flag width, ALU encoding {Z,C,N,O} in bits [3:0].
IDLE_FUNSEL, 4'b0000, FunSel driven to the ALU when no operation is in flight.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a / req0_b  in  DATA_W  requester 0 operands
req0_funsel  in  FUNSEL_W  requester 0 ALU function
req1_valid, req1_ready, req1_a, req1_b, req1_funsel  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes the response
rsp_id  out  1  requester that issued the operation (0/1)
rsp_result  out  DATA_W  ALU OutALU captured
rsp_flags  out  FLAG_W  ALU Flags captured
alu_a / alu_b  out  DATA_W  to ALU A / B
alu_funsel  out  FUNSEL_W  to ALU FunSel
alu_out  in  DATA_W  from ALU OutALU (combinational)
alu_flags  in  FLAG_W  from ALU Flags (registered inside the ALU on clk)
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- FSM states:
  - IDLE -> ISSUE on an accept handshake.
  - ISSUE -> CAPTURE unconditionally.
  - CAPTURE -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready=1.
- Arbitration, IDLE only:
  - Register last_grant.
  - One requester valid: grant it.
  - Both valid: grant the requester other than last_grant.
- reqN_ready is combinational:
  - reqN_ready = (state==IDLE) & reqN_valid & granted(N).
  - At most one ready is high per cycle; both are 0 outside IDLE.
- On handshake (valid&ready at an edge): latch a, b, funsel and id; set last_grant=id.
- ISSUE and CAPTURE: alu_a, alu_b, alu_funsel hold the latched operands. The ALU updates Flags at the end of ISSUE.
- CAPTURE edge: register rsp_result<=alu_out, rsp_flags<=alu_flags, rsp_id<=latched id.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_flags stay stable until the rsp_ready handshake.
  - rsp_ready=1 on the first RESP cycle still costs one cycle; the next accept happens at the earliest in the following IDLE cycle.
- Outside ISSUE and CAPTURE: alu_funsel=IDLE_FUNSEL, alu_a=alu_b=0.
- Latency: handshake at edge t -> ISSUE in cycle t+1 -> CAPTURE in t+2 -> rsp_valid high in t+3. Maximum throughput is 1 op per 4 cycles when rsp_ready is held at 1.
- Requesters hold valid and payload stable until ready. The arbiter re-decides every IDLE cycle, so a valid dropped before ready is simply ignored.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0.
  - alu_a=alu_b=0, alu_funsel=IDLE_FUNSEL, ready outputs=0, busy=0.
- Reset mid-operation: the in-flight operation is dropped, no response is produced and the FSM returns to IDLE. Reset has priority over all other events.
- rsp_ready while rsp_valid=0 is ignored.
- Widths: there is no arithmetic in the block; all data passes through at parameter width with no truncation.

Decomposition:
- Shared package alu_pkg holds:
  - The FunSel encodings: ADD 4'b0100, SUB 4'b0101, CMP 4'b0110, AND 4'b0111, OR 4'b1000, XOR 4'b1010, LSL 4'b1011, LSR 4'b1100, ASL 4'b1101, ASR 4'b1110, CSR 4'b1111.
  - The flag bit indices Z=3, C=2, N=1, O=0.
  - The arbiter state enum {IDLE, ISSUE, CAPTURE, RESP}.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a last_grant register and a combinational grant vector.
- The FSM and datapath registers stay in alu_share_arbiter.

Test Plan:
1. Single requester: req0 ADD a=8'h33, b=8'h0F, rsp_ready=1 -> req0_ready at the first edge; rsp_valid exactly 3 cycles later; rsp_id=0, rsp_result=8'h42, rsp_flags equal the ALU Flags after that cycle.
2. Simultaneous requests: both valid with req0 AND 8'hAA,8'hF0 and req1 OR 8'hAA,8'hF0 held -> responses in order id=0/8'hA0, then id=1/8'hFA. A third pair afterwards grants req0 again (alternation holds).
3. Backpressure: req1 XOR 8'hAA,8'hF0 with rsp_ready=0 for 5 cycles -> rsp_valid stays high with result 8'h5A stable; both readys stay 0 even with req0 valid; completes one cycle after rsp_ready=1.
4. Zero flag: req0 XOR 8'h55,8'h55 -> rsp_result=8'h00 and rsp_flags[3] (Z)=1. Then req0 OR 8'h01,8'h00 -> rsp_flags[3]=0.
5. Reset mid-operation: assert reset in CAPTURE -> the next cycle has rsp_valid=0, busy=0, alu_funsel=IDLE_FUNSEL; no response is ever produced for the dropped op; the first request after reset is accepted normally.
6. Idle behaviour: no valids for 10 cycles -> alu_funsel=IDLE_FUNSEL, alu_a=alu_b=0, busy=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : ALU FunSel encodings, flag bit positions and the state type
//                shared by the ALU-sharing arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_FS_ADD = 4'b0100;
    localparam logic [3:0] c_FS_SUB = 4'b0101;
    localparam logic [3:0] c_FS_CMP = 4'b0110;
    localparam logic [3:0] c_FS_AND = 4'b0111;
    localparam logic [3:0] c_FS_OR  = 4'b1000;
    localparam logic [3:0] c_FS_XOR = 4'b1010;
    localparam logic [3:0] c_FS_LSL = 4'b1011;
    localparam logic [3:0] c_FS_LSR = 4'b1100;
    localparam logic [3:0] c_FS_ASL = 4'b1101;
    localparam logic [3:0] c_FS_ASR = 4'b1110;
    localparam logic [3:0] c_FS_CSR = 4'b1111;

    // Flags word is {Z,C,N,O}
    localparam int c_FLAG_Z = 3;
    localparam int c_FLAG_C = 2;
    localparam int c_FLAG_N = 1;
    localparam int c_FLAG_O = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant; a tie goes to the requester that
//                did not win last time.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_update_id,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    // Starts at 1 so requester 0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (i_update) begin
            r_last_grant <= i_update_id;
        end
    end

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one 8-bit ALU between two requesters, returning
//                result, flags and requester ID on a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int                  DATA_W      = 8,
    parameter int                  FUNSEL_W    = 4,
    parameter int                  FLAG_W      = 4,
    parameter logic [FUNSEL_W-1:0] IDLE_FUNSEL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic [FUNSEL_W-1:0] req0_funsel,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    input  logic [FUNSEL_W-1:0] req1_funsel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [FUNSEL_W-1:0] alu_funsel,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic                busy
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_accept_id;
    logic                w_drive_alu;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [FUNSEL_W-1:0] r_funsel;
    logic                r_id;
    logic                r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_result;
    logic [FLAG_W-1:0]   r_rsp_flags;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .i_req       ({req1_valid, req0_valid}),
        .i_update    (w_accept),
        .i_update_id (w_accept_id),
        .o_grant     (w_grant)
    );

    assign req0_ready  = (r_state == IDLE) & req0_valid & w_grant[0];
    assign req1_ready  = (r_state == IDLE) & req1_valid & w_grant[1];
    assign w_accept    = req0_ready | req1_ready;
    assign w_accept_id = req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = CAPTURE;
            CAPTURE: w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Flags are registered inside the ALU, so they are valid only one edge
    // after the operands were first presented; sample both on the CAPTURE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_funsel     <= IDLE_FUNSEL;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= w_accept_id ? req1_a      : req0_a;
                r_b      <= w_accept_id ? req1_b      : req0_b;
                r_funsel <= w_accept_id ? req1_funsel : req0_funsel;
                r_id     <= w_accept_id;
            end
            if (r_state == CAPTURE) begin
                r_rsp_id     <= r_id;
                r_rsp_result <= alu_out;
                r_rsp_flags  <= alu_flags;
            end
        end
    end

    assign w_drive_alu = (r_state == ISSUE) || (r_state == CAPTURE);
    assign alu_a       = w_drive_alu ? r_a      : '0;
    assign alu_b       = w_drive_alu ? r_b      : '0;
    assign alu_funsel  = w_drive_alu ? r_funsel : IDLE_FUNSEL;

    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench with a behavioural ALU and a
//                transaction-level model of the shared-ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam logic [3:0] IDLE_FS = 4'b0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] req0_funsel = '0, req1_funsel = '0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0] rsp_result, alu_a, alu_b, alu_out;
    logic [3:0] rsp_flags, alu_funsel;
    logic [3:0] alu_flags_q = '0;
    logic [11:0] alu_comb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_W(8), .FUNSEL_W(4), .FLAG_W(4), .IDLE_FUNSEL(IDLE_FS)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_funsel(req0_funsel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_funsel(req1_funsel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funsel(alu_funsel),
        .alu_out(alu_out), .alu_flags(alu_flags_q), .busy(busy)
    );

    // Behavioural ALU: {Z,C,N,O, result}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] fs);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, o;
        s = '0; r = '0; c = 1'b0; o = 1'b0;
        case (fs)
            c_FS_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            c_FS_SUB, c_FS_CMP: begin
                r = a - b; c = (a >= b);
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            c_FS_AND: r = a & b;
            c_FS_OR:  r = a | b;
            c_FS_XOR: r = a ^ b;
            c_FS_LSL: begin r = {a[6:0], 1'b0}; c = a[7]; end
            c_FS_ASL: begin r = {a[6:0], 1'b0}; c = a[7]; o = a[7] ^ a[6]; end
            c_FS_LSR: begin r = {1'b0, a[7:1]}; c = a[0]; end
            c_FS_ASR: begin r = {a[7], a[7:1]}; c = a[0]; end
            c_FS_CSR: begin r = {a[0], a[7:1]}; c = a[0]; end
            default:  r = '0;
        endcase
        return {(r == 8'h00), c, r[7], o, r};
    endfunction

    assign alu_comb = alu_fn(alu_a, alu_b, alu_funsel);
    assign alu_out  = alu_comb[7:0];
    always @(posedge clk) if (alu_funsel != IDLE_FS) alu_flags_q <= alu_comb[11:8];

    // ---------------- transaction-level reference model ----------------
    // m_age: -1 = free, otherwise cycles since the accepted request
    int         m_age = -1;
    logic       m_last = 1'b1, m_id = 1'b0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [3:0] m_fs = '0;
    logic       exp_r0, exp_r1, exp_busy, exp_rvalid, exp_id, acc0, acc1;
    logic [7:0] exp_alu_a, exp_alu_b, exp_res;
    logic [3:0] exp_alu_fs, exp_flags;

    task automatic model_predict();
        logic [11:0] f;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (m_age < 0) begin
            if (req0_valid && req1_valid) begin
                exp_r0 = m_last;
                exp_r1 = !m_last;
            end else begin
                exp_r0 = req0_valid;
                exp_r1 = req1_valid;
            end
        end
        exp_busy   = (m_age >= 0);
        exp_rvalid = (m_age == 3);
        if (m_age == 1 || m_age == 2) begin
            exp_alu_a = m_a; exp_alu_b = m_b; exp_alu_fs = m_fs;
        end else begin
            exp_alu_a = '0; exp_alu_b = '0; exp_alu_fs = IDLE_FS;
        end
        f = alu_fn(m_a, m_b, m_fs);
        exp_id = m_id; exp_res = f[7:0]; exp_flags = f[11:8];
    endtask

    task automatic model_commit();
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (reset) begin
            m_age = -1; m_last = 1'b1;
        end else if (m_age < 0) begin
            if (exp_r0 || exp_r1) begin
                acc0 = exp_r0; acc1 = exp_r1;
                m_id = exp_r1; m_last = exp_r1; m_age = 1;
                m_a  = exp_r1 ? req1_a : req0_a;
                m_b  = exp_r1 ? req1_b : req0_b;
                m_fs = exp_r1 ? req1_funsel : req0_funsel;
            end
        end else if (m_age < 3) begin
            m_age++;
        end else if (rsp_ready) begin
            m_age = -1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_predict();
    endtask

    // Requesters drop valid once their operation has been taken
    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        advance();
        reset = 1'b0;
    endtask

    task automatic drain();
        logic done = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            sample();
            if (m_age < 0 && !req0_valid && !req1_valid) begin
                done = 1'b1;
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_busy got=%b exp=0", busy); end
            end
            advance();
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL drain_timeout got=busy exp=idle"); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b0;
        sample(); advance();
        sample();
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
        vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_id got=%b exp=0", rsp_id); end
        vectors++; if (rsp_result !== 8'h00) begin miscompares++; $display("FAIL rst_rsp_result got=%h exp=00", rsp_result); end
        vectors++; if (rsp_flags !== 4'h0) begin miscompares++; $display("FAIL rst_rsp_flags got=%h exp=0", rsp_flags); end
        vectors++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin miscompares++; $display("FAIL rst_alu_ab got=%h/%h exp=00/00", alu_a, alu_b); end
        vectors++; if (alu_funsel !== IDLE_FS) begin miscompares++; $display("FAIL rst_alu_funsel got=%h exp=%h", alu_funsel, IDLE_FS); end
        advance();
        reset = 1'b0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h0F; req0_funsel = c_FS_ADD; rsp_ready = 1'b1;
        sample();
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready got=%b%b exp=01", req1_ready, req0_ready); end
        advance();
        sample();
        vectors++; if (alu_a !== 8'h33 || alu_b !== 8'h0F || alu_funsel !== c_FS_ADD) begin miscompares++; $display("FAIL single_issue_alu got=%h,%h,%h exp=33,0f,%h", alu_a, alu_b, alu_funsel, c_FS_ADD); end
        vectors++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_issue_state got busy=%b vld=%b exp=1/0", busy, rsp_valid); end
        advance();
        sample();
        vectors++; if (rsp_valid !== 1'b0 || alu_funsel !== c_FS_ADD) begin miscompares++; $display("FAIL single_capture got vld=%b fs=%h exp=0/%h", rsp_valid, alu_funsel, c_FS_ADD); end
        advance();
        sample();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0 || rsp_result !== 8'h42) begin miscompares++; $display("FAIL single_rsp_data got id=%b res=%h exp=0/42", rsp_id, rsp_result); end
        vectors++; if (rsp_flags !== 4'b0000) begin miscompares++; $display("FAIL single_rsp_flags got=%b exp=0000", rsp_flags); end
        advance();
        sample();
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done got vld=%b busy=%b exp=0/0", rsp_valid, busy); end
        advance();
    endtask

    task automatic test_simultaneous();
        int         got = 0;
        logic       eid;
        logic [7:0] eres;
        do_reset();
        req0_a = 8'hAA; req0_b = 8'hF0; req0_funsel = c_FS_AND;
        req1_a = 8'hAA; req1_b = 8'hF0; req1_funsel = c_FS_OR;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int n = 0; n < 20 && got < 2; n++) begin
            sample();
            if (rsp_valid && rsp_ready) begin
                eid  = (got != 0);
                eres = (got == 0) ? 8'hA0 : 8'hFA;
                vectors++; if (rsp_id !== eid || rsp_result !== eres) begin miscompares++; $display("FAIL simul_rsp%0d got id=%b res=%h exp=%b/%h", got, rsp_id, rsp_result, eid, eres); end
                got++;
            end
            advance();
        end
        vectors++; if (got != 2) begin miscompares++; $display("FAIL simul_timeout got=%0d exp=2 responses", got); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        sample();
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL simul_alternate got=%b%b exp=01", req1_ready, req0_ready); end
        advance();
        drain();
    endtask

    task automatic test_backpressure();
        logic found = 1'b0;
        req1_a = 8'hAA; req1_b = 8'hF0; req1_funsel = c_FS_XOR; req1_valid = 1'b1;
        rsp_ready = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            sample(); found = rsp_valid; advance();
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL bp_timeout got=no_rsp exp=rsp_valid"); end
        req0_a = 8'h01; req0_b = 8'h02; req0_funsel = c_FS_ADD; req0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 8'h5A) begin miscompares++; $display("FAIL bp_hold%0d got vld=%b id=%b res=%h exp=1/1/5a", k, rsp_valid, rsp_id, rsp_result); end
            vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d got=%b%b exp=00", k, req1_ready, req0_ready); end
            advance();
        end
        rsp_ready = 1'b1;
        sample();
        vectors++; if (rsp_valid !== 1'b1 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_release got vld=%b rdy0=%b exp=1/0", rsp_valid, req0_ready); end
        advance();
        sample();
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after got vld=%b busy=%b rdy0=%b exp=0/0/1", rsp_valid, busy, req0_ready); end
        advance();
        drain();
    endtask

    task automatic test_zero_flag();
        logic [7:0] ta [2] = '{8'h55, 8'h01};
        logic [7:0] tb [2] = '{8'h55, 8'h00};
        logic [3:0] tf [2] = '{c_FS_XOR, c_FS_OR};
        logic [7:0] tr [2] = '{8'h00, 8'h01};
        logic       tz [2] = '{1'b1, 1'b0};
        logic       found;
        rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            req0_a = ta[t]; req0_b = tb[t]; req0_funsel = tf[t]; req0_valid = 1'b1;
            found = 1'b0;
            for (int n = 0; n < 10 && !found; n++) begin
                sample();
                if (rsp_valid) begin
                    found = 1'b1;
                    vectors++; if (rsp_result !== tr[t]) begin miscompares++; $display("FAIL zero%0d_result got=%h exp=%h", t, rsp_result, tr[t]); end
                    vectors++; if (rsp_flags[c_FLAG_Z] !== tz[t]) begin miscompares++; $display("FAIL zero%0d_zflag got=%b exp=%b", t, rsp_flags[c_FLAG_Z], tz[t]); end
                end
                advance();
            end
            vectors++; if (!found) begin miscompares++; $display("FAIL zero%0d_timeout got=no_rsp exp=rsp_valid", t); end
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        req0_a = 8'h10; req0_b = 8'h20; req0_funsel = c_FS_ADD; req0_valid = 1'b1; rsp_ready = 1'b1;
        sample();
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_accept got=%b exp=1", req0_ready); end
        advance();
        sample(); advance();
        reset = 1'b1;
        sample();
        vectors++; if (alu_funsel !== c_FS_ADD) begin miscompares++; $display("FAIL rmid_capture got=%h exp=%h", alu_funsel, c_FS_ADD); end
        advance();
        reset = 1'b0;
        sample();
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_funsel !== IDLE_FS) begin miscompares++; $display("FAIL rmid_after got vld=%b busy=%b fs=%h exp=0/0/%h", rsp_valid, busy, alu_funsel, IDLE_FS); end
        advance();
        for (int k = 0; k < 6; k++) begin
            sample();
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_norsp%0d got=%b exp=0", k, rsp_valid); end
            advance();
        end
        req1_a = 8'h50; req1_b = 8'h20; req1_funsel = c_FS_SUB; req1_valid = 1'b1;
        sample();
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_reaccept got=%b exp=1", req1_ready); end
        advance();
        for (int n = 0; n < 10 && !found; n++) begin
            sample();
            if (rsp_valid) begin
                found = 1'b1;
                vectors++; if (rsp_id !== 1'b1 || rsp_result !== 8'h30) begin miscompares++; $display("FAIL rmid_rsp got id=%b res=%h exp=1/30", rsp_id, rsp_result); end
            end
            advance();
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rmid_timeout got=no_rsp exp=rsp_valid"); end
    endtask

    task automatic test_idle();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample();
            vectors++; if (alu_funsel !== IDLE_FS) begin miscompares++; $display("FAIL idle_fs%0d got=%h exp=%h", k, alu_funsel, IDLE_FS); end
            vectors++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin miscompares++; $display("FAIL idle_ab%0d got=%h/%h exp=00/00", k, alu_a, alu_b); end
            vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL idle_state%0d got busy=%b vld=%b exp=0/0", k, busy, rsp_valid); end
            advance();
        end
    endtask

    task automatic test_random();
        logic [3:0] fs_tab [11] = '{c_FS_ADD, c_FS_SUB, c_FS_CMP, c_FS_AND, c_FS_OR, c_FS_XOR,
                                    c_FS_LSL, c_FS_LSR, c_FS_ASL, c_FS_ASR, c_FS_CSR};
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom);
                req0_funsel = fs_tab[$urandom_range(0, 10)];
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom);
                req1_funsel = fs_tab[$urandom_range(0, 10)];
            end
            rsp_ready = 1'($urandom_range(0, 1));
            sample();
            vectors++; if (req0_ready !== exp_r0 || req1_ready !== exp_r1) begin miscompares++; $display("FAIL rnd_ready c%0d got=%b%b exp=%b%b", i, req1_ready, req0_ready, exp_r1, exp_r0); end
            vectors++; if (busy !== exp_busy || rsp_valid !== exp_rvalid) begin miscompares++; $display("FAIL rnd_state c%0d got busy=%b vld=%b exp=%b/%b", i, busy, rsp_valid, exp_busy, exp_rvalid); end
            vectors++; if (alu_a !== exp_alu_a || alu_b !== exp_alu_b || alu_funsel !== exp_alu_fs) begin miscompares++; $display("FAIL rnd_alu c%0d got=%h,%h,%h exp=%h,%h,%h", i, alu_a, alu_b, alu_funsel, exp_alu_a, exp_alu_b, exp_alu_fs); end
            if (exp_rvalid) begin
                vectors++; if (rsp_id !== exp_id || rsp_result !== exp_res || rsp_flags !== exp_flags) begin miscompares++; $display("FAIL rnd_rsp c%0d got id=%b res=%h flg=%b exp=%b/%h/%b", i, rsp_id, rsp_result, rsp_flags, exp_id, exp_res, exp_flags); end
            end
            advance();
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_zero_flag();
        test_reset_mid();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
